axil2apb_bridge: RTL and testbench
==================================

Name: axil2apb_bridge

Overview:
- AXI4-Lite slave to APB master bridge; the single master that drives the APB slave port of the periphery block (timers, RTC).
- Sits between the core/interconnect AXI4-Lite peripheral window and the APB bus.
- One transaction in flight. Decodes the peripheral window, sequences APB SETUP/ACCESS phases and returns AXI B/R responses.

Parameters:
- APB_AW, 32, APB address width; PADDR carries the low APB_AW bits of the AXI address.
- APB_DW, 32, data width on both AXI and APB sides; only 32 is supported.
- PERIPH_BA, 32'h9000_0000, base of the decoded window.
- PERIPH_SIZE, 32'h0001_0000, window size in bytes; must be a power of two and aligned to PERIPH_BA.
- TIMEOUT_CYCLES, 256, ACCESS-phase wait limit; used only with APB_TIMEOUT_EN.

Ports:
- pclk in 1: clock shared by both AXI and APB sides.
- prst in 1: reset, asynchronous, active-high.
- s_awaddr in 32 / s_awvalid in 1 / s_awready out 1: AXI write address channel.
- s_wdata in APB_DW / s_wstrb in APB_DW/8 / s_wvalid in 1 / s_wready out 1: AXI write data channel.
- s_bresp out 2 / s_bvalid out 1 / s_bready in 1: AXI write response channel.
- s_araddr in 32 / s_arvalid in 1 / s_arready out 1: AXI read address channel.
- s_rdata out APB_DW / s_rresp out 2 / s_rvalid out 1 / s_rready in 1: AXI read data channel.
- paddr out APB_AW / psel out 1 / penable out 1 / pwrite out 1 / pwdata out APB_DW / pstrb out APB_DW/8: APB master outputs.
- prdata in APB_DW / pready in 1: APB slave returns.

Behaviour:
- Reset: all outputs 0. FSM = IDLE. Priority pointer = WRITE.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE, request selection:
  - A write is pending only when s_awvalid and s_wvalid are both 1. AW without W, or W without AW, is not pending.
  - With both write and read pending, the pointer picks; the pointer toggles after each granted transaction (round-robin).
- IDLE, accept:
  - s_awready=s_wready=1 (write) or s_arready=1 (read), combinationally, only in IDLE and only for the selected request.
  - The handshake completes on that edge. Address, data and strobe are latched.
- Decode:
  - Hit when (addr & ~(PERIPH_SIZE-1)) == PERIPH_BA.
  - Miss: go IDLE->RESP with resp=2'b11 (DECERR) and rdata=0. No APB activity.
- SETUP (1 cycle):
  - psel=1, penable=0.
  - paddr = addr[APB_AW-1:0], pwrite set.
  - pwdata/pstrb = latched data/strobe for writes; pstrb=0 for reads.
- ACCESS:
  - psel=1, penable=1. Hold until pready=1.
  - On the pready edge: capture prdata (reads), set resp=OKAY, go RESP.
  - psel and penable drop in the following cycle.
- APB outputs are stable from SETUP through the last ACCESS cycle.
- RESP:
  - Write: s_bvalid=1. Read: s_rvalid=1 with s_rdata/s_rresp.
  - Hold until s_bready or s_rready. Handshake edge -> IDLE.
  - Valid deasserts the cycle after the handshake.
- Minimum latency, zero-wait slave with ready held high: accept edge N, SETUP at N+1, ACCESS at N+2, valid at N+3, IDLE at N+4.
- Back-to-back: the next accept happens earliest in the IDLE cycle after RESP completes. No overlap.
- pwdata/paddr outside SETUP/ACCESS: keep last value.
- prst asserted mid-transaction:
  - psel, penable and valid outputs go to 0 immediately.
  - FSM returns to IDLE. The in-flight transaction is dropped with no response.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - A counter clears on SETUP entry and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYCLES-1 with pready still 0: abort. psel/penable drop next cycle. RESP with resp=2'b10 (SLVERR), rdata=0.
  - pready=1 on the limit cycle wins: normal OKAY completion.
- Not defined: no counter; ACCESS waits indefinitely.

Test Plan:
- Write 0x9000_0004 data 0xDEAD_BEEF strb 0xF, pready tied 1 -> one SETUP and one ACCESS with paddr=0x9000_0004, pwrite=1; bvalid 3 cycles after accept, bresp=00.
- Read 0x9000_0008, slave returns 0x1234_5678 after 3 wait states -> penable high 4 cycles; rdata=0x1234_5678, rresp=00.
- Read 0x8000_0000 -> no psel pulse; rresp=11, rdata=0. Write same address -> bresp=11.
- AW, W and AR asserted together twice in a row -> write granted first, then read; then reversed on the next pair. Also: AW alone for 5 cycles -> no accept until W arrives.
- bready held 0 for 4 cycles -> bvalid stays 1, no new accept; prst pulsed during ACCESS -> psel=0 same cycle, no B/R response afterwards.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready stuck 0 -> SLVERR after 16 ACCESS cycles; pready rising on cycle 16 -> OKAY.

Source files
------------

// File: rtl/axil2apb_bridge.sv
// axil2apb_bridge: AXI4-Lite slave to APB master bridge, one transaction in flight
//   pclk, prst           : shared clock, asynchronous active-high reset
//   s_aw*/s_w*/s_b*      : AXI4-Lite write address, data and response channels
//   s_ar*/s_r*           : AXI4-Lite read address and data channels
//   paddr..pstrb         : APB master request outputs
//   prdata, pready       : APB slave returns
//   APB_TIMEOUT_EN       : when defined, ACCESS aborts with SLVERR after TIMEOUT_CYCLES
module axil2apb_bridge #(
    parameter int          APB_AW         = 32,
    parameter int          APB_DW         = 32,
    parameter logic [31:0] PERIPH_BA      = 32'h9000_0000,
    parameter logic [31:0] PERIPH_SIZE    = 32'h0001_0000,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic                pclk,
    input  logic                prst,
    input  logic [31:0]         s_awaddr,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [APB_DW-1:0]   s_wdata,
    input  logic [APB_DW/8-1:0] s_wstrb,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [31:0]         s_araddr,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [APB_DW-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic [APB_AW-1:0]   paddr,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [APB_DW-1:0]   pwdata,
    output logic [APB_DW/8-1:0] pstrb,
    input  logic [APB_DW-1:0]   prdata,
    input  logic                pready
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t      state;
    logic        ptr_rd;
    logic        is_wr;
    logic [1:0]  resp;
    logic        wr_pend, rd_pend, grant_wr, grant_rd, hit, timeout;
    logic [31:0] req_addr;

    if (APB_DW != 32 || PERIPH_SIZE == 0 || (PERIPH_SIZE & (PERIPH_SIZE - 32'd1)) != 0 ||
        (PERIPH_BA & (PERIPH_SIZE - 32'd1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("axil2apb_bridge: unsupported parameter set");
    end

    // Write needs both AW and W; the pointer only arbitrates when both kinds are pending.
    always_comb begin
        wr_pend  = s_awvalid & s_wvalid;
        rd_pend  = s_arvalid;
        grant_wr = state == IDLE && !prst && wr_pend && (!rd_pend || !ptr_rd);
        grant_rd = state == IDLE && !prst && rd_pend && !grant_wr;
        req_addr = grant_wr ? s_awaddr : s_araddr;
        hit      = (req_addr & ~(PERIPH_SIZE - 32'd1)) == PERIPH_BA;
    end

    assign s_awready = grant_wr;
    assign s_wready  = grant_wr;
    assign s_arready = grant_rd;
    assign s_bresp   = resp;
    assign s_rresp   = resp;

`ifdef APB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] to_cnt;
    assign timeout = to_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state    <= IDLE;
            ptr_rd   <= 1'b0;
            is_wr    <= 1'b0;
            resp     <= 2'b00;
            s_bvalid <= 1'b0;
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            paddr    <= '0;
            psel     <= 1'b0;
            penable  <= 1'b0;
            pwrite   <= 1'b0;
            pwdata   <= '0;
            pstrb    <= '0;
`ifdef APB_TIMEOUT_EN
            to_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (grant_wr || grant_rd) begin
                    is_wr <= grant_wr;
                    if (wr_pend && rd_pend) ptr_rd <= !ptr_rd;
`ifdef APB_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    if (hit) begin
                        state  <= SETUP;
                        psel   <= 1'b1;
                        paddr  <= req_addr[APB_AW-1:0];
                        pwrite <= grant_wr;
                        pstrb  <= grant_wr ? s_wstrb : '0;
                        if (grant_wr) pwdata <= s_wdata;
                    end else begin
                        // Decode miss answers directly, the APB bus stays untouched.
                        state    <= RESP;
                        resp     <= 2'b11;
                        s_bvalid <= grant_wr;
                        s_rvalid <= grant_rd;
                        if (grant_rd) s_rdata <= '0;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                end
                ACCESS: if (pready || timeout) begin
                    state    <= RESP;
                    psel     <= 1'b0;
                    penable  <= 1'b0;
                    resp     <= pready ? 2'b00 : 2'b10;
                    s_bvalid <= is_wr;
                    s_rvalid <= !is_wr;
                    if (!is_wr) s_rdata <= pready ? prdata : '0;
                end else begin
`ifdef APB_TIMEOUT_EN
                    to_cnt <= to_cnt + TW'(1);
`endif
                end
                RESP: if ((s_bvalid && s_bready) || (s_rvalid && s_rready)) begin
                    state    <= IDLE;
                    s_bvalid <= 1'b0;
                    s_rvalid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil2apb_bridge.sv
// tb_axil2apb_bridge: directed plus randomized checks of axil2apb_bridge against a transaction-level model
module tb_axil2apb_bridge;
    localparam int TO = 16;
`ifdef APB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        pclk = 1'b0, prst = 1'b1;
    logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0, s_rdata, pwdata, paddr;
    logic [31:0] prdata = '0, rd_val = '0;
    logic [3:0]  s_wstrb = '0, pstrb;
    logic [1:0]  s_bresp, s_rresp;
    logic        s_awvalid = 0, s_wvalid = 0, s_arvalid = 0, s_bready = 0, s_rready = 0, pready = 0;
    logic        s_awready, s_wready, s_arready, s_bvalid, s_rvalid, psel, penable, pwrite;
    int          vectors = 0, errs = 0;
    bit          prio_wr = 1'b1;

    always #5 pclk = ~pclk;

    axil2apb_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .pclk(pclk), .prst(prst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_window(input logic [31:0] a);
        return a >= 32'h9000_0000 && a <= 32'h9000_FFFF;
    endfunction

    task automatic drive(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (wr) begin
            s_awaddr = a; s_wdata = d; s_wstrb = s; s_awvalid = 1; s_wvalid = 1;
        end else begin
            s_araddr = a; s_arvalid = 1;
        end
    endtask

    task automatic wait_accept(input bit wr);
        int k;
        for (k = 0; k < 20; k++) begin
            #1;
            if (wr ? (s_awready && s_wready) : s_arready) break;
            @(negedge pclk);
        end
        chk(wr ? "aw_accept" : "ar_accept", 32'(k < 20), 32'd1);
        @(posedge pclk);
        #1;
        if (wr) begin s_awvalid = 0; s_wvalid = 0; end else s_arvalid = 0;
        @(negedge pclk);
    endtask

    // Called on the falling edge right after the accepting edge; follows the transaction to its response.
    task automatic finish(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int waits, input int bdly);
        logic [31:0] sa, sd, exp_rd;
        logic [3:0]  ss;
        logic [1:0]  exp_resp;
        bit          sw, stable, h, to;
        int          ns, na, t, exp_acc;
        h        = in_window(a);
        to       = h && TO_EN && waits >= TO;
        exp_acc  = to ? TO : waits + 1;
        exp_rd   = (h && !to) ? rd_val : 32'd0;
        exp_resp = !h ? 2'b11 : to ? 2'b10 : 2'b00;
        ns = 0; na = 0; stable = 1; sa = '0; sd = '0; ss = '0; sw = 0;
        for (t = 0; t < 400; t++) begin
            #1;
            if (s_bvalid || s_rvalid) break;
            if (psel) begin
                if (ns + na == 0) begin sa = paddr; sd = pwdata; ss = pstrb; sw = pwrite; end
                else if ({sa, sd, ss, sw} !== {paddr, pwdata, pstrb, pwrite}) stable = 0;
                if (penable) na++; else ns++;
            end
            pready = psel && penable && na == waits + 1;
            prdata = pready ? rd_val : $urandom();
            @(negedge pclk);
        end
        pready = 0;
        chk("latency", 32'(t), 32'(h ? exp_acc + 1 : 0));
        chk("bvalid", 32'(s_bvalid), 32'(wr));
        chk("rvalid", 32'(s_rvalid), 32'(!wr));
        chk("resp", 32'(wr ? s_bresp : s_rresp), 32'(exp_resp));
        if (!wr) chk("rdata", s_rdata, exp_rd);
        if (h) begin
            chk("setup_cycles", 32'(ns), 32'd1);
            chk("access_cycles", 32'(na), 32'(exp_acc));
            chk("paddr", sa, a);
            chk("pwrite", 32'(sw), 32'(wr));
            chk("pstrb", 32'(ss), 32'(wr ? s : 4'h0));
            if (wr) chk("pwdata", sd, d);
            chk("apb_stable", 32'(stable), 32'd1);
        end else chk("no_apb", 32'(ns + na), 32'd0);
        chk("psel_in_resp", 32'(psel), 32'd0);
        for (int i = 0; i < bdly; i++) begin
            @(negedge pclk);
            #1;
            chk("valid_hold", 32'(wr ? s_bvalid : s_rvalid), 32'd1);
            chk("no_accept", 32'(s_awready | s_arready), 32'd0);
        end
        if (wr) s_bready = 1; else s_rready = 1;
        @(posedge pclk);
        #1;
        s_bready = 0; s_rready = 0;
        @(negedge pclk);
        #1;
        chk("valid_drop", 32'(s_bvalid | s_rvalid), 32'd0);
    endtask

    task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int waits, input int bdly);
        drive(wr, a, d, s);
        wait_accept(wr);
        finish(wr, a, d, s, waits, bdly);
    endtask

    task automatic contest(input int waits);
        logic [31:0] wa, ra, wd;
        bit first;
        wa = 32'h9000_0000 | 32'($urandom_range(0, 255) << 2);
        ra = 32'h9000_0400 | 32'($urandom_range(0, 255) << 2);
        wd = $urandom();
        rd_val = $urandom();
        drive(1, wa, wd, 4'hF);
        drive(0, ra, 32'd0, 4'h0);
        #1;
        chk("contest_aw", 32'(s_awready), 32'(prio_wr));
        chk("contest_ar", 32'(s_arready), 32'(!prio_wr));
        first = prio_wr;
        prio_wr = !prio_wr;
        wait_accept(first);
        finish(first, first ? wa : ra, wd, 4'hF, waits, 0);
        wait_accept(!first);
        finish(!first, first ? ra : wa, wd, 4'hF, waits, 0);
    endtask

    initial begin
        repeat (2) @(negedge pclk);
        #1;
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_rdata", s_rdata, 32'd0);
        chk("rst_ctl", 32'({psel, penable, pwrite, pstrb, s_awready, s_wready, s_arready,
                            s_bvalid, s_rvalid, s_bresp, s_rresp}), 32'd0);
        @(negedge pclk);
        prst = 0;
        @(negedge pclk);

        txn(1, 32'h9000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0);
        rd_val = 32'h1234_5678;
        txn(0, 32'h9000_0008, 32'd0, 4'h0, 3, 0);
        txn(0, 32'h8000_0000, 32'd0, 4'h0, 0, 1);
        txn(1, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, 0, 0);

        contest(0);
        contest(1);

        s_awaddr = 32'h9000_0100; s_awvalid = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("aw_alone", 32'({s_awready, s_wready}), 32'd0);
            @(negedge pclk);
        end
        s_wdata = 32'hCAFE_0001; s_wstrb = 4'h3; s_wvalid = 1;
        wait_accept(1);
        finish(1, 32'h9000_0100, 32'hCAFE_0001, 4'h3, 1, 0);

        drive(1, 32'h9000_0200, 32'h5555_AAAA, 4'h9);
        wait_accept(1);
        drive(0, 32'h9000_0204, 32'd0, 4'h0);
        finish(1, 32'h9000_0200, 32'h5555_AAAA, 4'h9, 0, 4);
        rd_val = 32'h0F0F_7777;
        wait_accept(0);
        finish(0, 32'h9000_0204, 32'd0, 4'h0, 2, 0);

        rd_val = 32'hA1B2_C3D4;
        txn(0, 32'h9000_0300, 32'd0, 4'h0, TO - 1, 0);
        txn(1, 32'h9000_0304, 32'h7777_1234, 4'hF, TO + 4, 0);
        txn(0, 32'h9000_0308, 32'd0, 4'h0, TO + 4, 0);

        rd_val = 32'h600D_600D;
        drive(0, 32'h9000_0010, 32'd0, 4'h0);
        wait_accept(0);
        @(negedge pclk);
        #2;
        prst = 1;
        #1;
        chk("rst_mid_psel", 32'({psel, penable}), 32'd0);
        chk("rst_mid_valid", 32'({s_bvalid, s_rvalid}), 32'd0);
        @(negedge pclk);
        prst = 0;
        prio_wr = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            #1;
            chk("rst_dropped", 32'({psel, s_bvalid, s_rvalid}), 32'd0);
        end

        for (int n = 0; n < 25; n++) begin
            bit          wr;
            logic [31:0] a;
            int          sel;
            wr  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 5);
            a   = sel == 0 ? 32'h9001_0000 : sel == 1 ? 32'h8FFF_FFFC : sel == 2 ? 32'h9000_FFFC :
                  sel == 3 ? ($urandom() & 32'hFFFF_FFFC) : 32'h9000_0000 + 32'($urandom_range(0, 16383) << 2);
            rd_val = $urandom();
            txn(wr, a, $urandom(), 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
